// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared defaults, pixel type and stream-lock state encoding
//               for the video output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  localparam int C_DATA_W   = 24;
  localparam int C_H_ACTIVE = 640;
  localparam int C_V_ACTIVE = 480;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ARMED    = 2'd1,
    ACTIVE   = 2'd2
  } stream_state_e;

endpackage
`default_nettype wire

// File: rtl/video_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : video_delay_line
// Description : Fixed-depth shift register. Every stage resets
//               asynchronously to RESET_VAL so the output is idle before
//               the first real sample has propagated through.
// Ports       : clk, reset (async, active-high), d (WIDTH in), q (WIDTH out,
//               d delayed by DEPTH clocks)
// Revision    : 1.0 - initial release
// ============================================================================
module video_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_out
// Description : Output stage behind the timing generator. Locks a valid/ready
//               pixel stream to the raster using tuser (SOF) and tlast (EOL),
//               fills starved or unlocked active slots with FILL_COLOR and
//               drops back to SOF search on any framing error. Pixel and syncs
//               share one PIPE_LAT-deep delay line so they stay aligned.
// Ports       : clk, reset (async, active-high)
//               hsync_in/vsync_in/vde_in/x_in/y_in/start_of_frame_in/
//               end_of_line_in : raster from the timing generator
//               s_tdata/s_tvalid/s_tready/s_tuser/s_tlast : pixel stream
//               rgb_out/hsync_out/vsync_out/vde_out : aligned outputs
//               locked, underflow_cnt, resync_cnt : status
// Revision    : 1.0 - initial release
// ============================================================================
module video_stream_out
  import video_pkg::*;
#(
  parameter int                DATA_W     = C_DATA_W,
  parameter int                H_ACTIVE   = C_H_ACTIVE,
  parameter int                V_ACTIVE   = C_V_ACTIVE,
  parameter int                PIPE_LAT   = 2,
  parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              vde_in,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  input  logic              start_of_frame_in,
  input  logic              end_of_line_in,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              vde_out,
  output logic              locked,
  output logic [15:0]       underflow_cnt,
  output logic [7:0]        resync_cnt
);

  localparam int               C_DL_W   = DATA_W + 3;
  // Idle raster: black pixel, syncs deasserted (high), video disabled.
  localparam logic [C_DL_W-1:0] C_DL_RST = {{DATA_W{1'b0}}, 3'b110};
  localparam logic [9:0]        C_X_LAST = 10'(H_ACTIVE - 1);

  stream_state_e r_state;
  stream_state_e w_next_state;

  logic              w_ready;
  logic              w_hs;
  logic              w_take;
  logic              w_err;
  logic              w_underflow;
  logic [DATA_W-1:0] w_pix;
  logic              w_at_x_last;
  logic              r_locked;
  logic [15:0]       r_underflow_cnt;
  logic [7:0]        r_resync_cnt;
  logic [C_DL_W-1:0] w_dl_in;
  logic [C_DL_W-1:0] w_dl_out;
  logic              w_unused;

  // Line/frame geometry beyond the last-pixel column is implied by the
  // markers themselves, so these raster inputs are not needed for locking.
  assign w_unused = ^{(y_in < 10'(V_ACTIVE)), end_of_line_in};

  // --------------------------------------------------------------------------
  // Ready decode. In WAIT_SOF everything ahead of the SOF pixel is drained;
  // in ACTIVE a tuser pixel is held back until the raster reaches (0,0).
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      WAIT_SOF: w_ready = s_tvalid && !s_tuser;
      ARMED:    w_ready = start_of_frame_in && vde_in;
      ACTIVE:   w_ready = vde_in && !(s_tuser && !start_of_frame_in);
      default:  w_ready = 1'b0;
    endcase
  end

  assign s_tready    = w_ready && !reset;
  assign w_hs        = s_tvalid && w_ready;
  // Pixels drained while searching for SOF never reach the screen.
  assign w_take      = w_hs && (r_state != WAIT_SOF);
  assign w_at_x_last = (x_in == C_X_LAST);

  assign w_err = (r_state == ACTIVE) && vde_in &&
                 ((start_of_frame_in && (!s_tvalid || !s_tuser)) ||
                  (s_tvalid && s_tuser && !start_of_frame_in)    ||
                  (w_hs && s_tlast && !w_at_x_last)              ||
                  (w_hs && !s_tlast && w_at_x_last));

  // A starved slot is simply lost; any resulting offset shows up at the
  // next tlast check rather than being recovered here.
  assign w_underflow = (r_state == ACTIVE) && vde_in && !s_tvalid && !w_err;

  assign w_pix = w_take ? s_tdata : (vde_in ? FILL_COLOR : '0);

  // --------------------------------------------------------------------------
  // Lock FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_SOF: if (s_tvalid && s_tuser) w_next_state = ARMED;
      ARMED:    if (w_hs)                w_next_state = ACTIVE;
      ACTIVE:   if (w_err)               w_next_state = WAIT_SOF;
      default:                           w_next_state = WAIT_SOF;
    endcase
  end

  // --------------------------------------------------------------------------
  // Status: locked tracks the state register exactly; counters saturate.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_locked        <= 1'b0;
      r_underflow_cnt <= '0;
      r_resync_cnt    <= '0;
    end else begin
      r_locked <= (w_next_state == ACTIVE);
      if (w_underflow && (r_underflow_cnt != 16'hFFFF)) begin
        r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
      if (w_err && (r_resync_cnt != 8'hFF)) begin
        r_resync_cnt <= r_resync_cnt + 8'd1;
      end
    end
  end

  assign locked        = r_locked;
  assign underflow_cnt = r_underflow_cnt;
  assign resync_cnt    = r_resync_cnt;

  // --------------------------------------------------------------------------
  // Shared output pipeline
  // --------------------------------------------------------------------------
  assign w_dl_in = {w_pix, hsync_in, vsync_in, vde_in};

  video_delay_line #(
    .WIDTH     (C_DL_W),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (C_DL_RST)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     (w_dl_in),
    .q     (w_dl_out)
  );

  assign {rgb_out, hsync_out, vsync_out, vde_out} = w_dl_out;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_stream_out
// Description : Self-checking bench for video_stream_out on a reduced raster
//               (16x4 active, 20x10 total). A queue-based stream source feeds
//               frames; expected outputs are pushed to a scoreboard when the
//               inputs are driven and popped PIPE_LAT clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_stream_out;

  localparam int          DW   = 24;
  localparam int          HA   = 16;
  localparam int          VA   = 4;
  localparam int          HT   = 20;
  localparam int          VT   = 10;
  localparam int          PL   = 2;
  localparam int          FR   = HT * VT;
  localparam logic [23:0] FILL = 24'hABCDEF;

  logic          clk;
  logic          reset;
  logic          hsync_in, vsync_in, vde_in;
  logic [9:0]    x_in, y_in;
  logic          start_of_frame_in, end_of_line_in;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tuser, s_tlast;
  logic [DW-1:0] rgb_out;
  logic          hsync_out, vsync_out, vde_out, locked;
  logic [15:0]   underflow_cnt;
  logic [7:0]    resync_cnt;

  video_stream_out #(
    .DATA_W     (DW),
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .PIPE_LAT   (PL),
    .FILL_COLOR (FILL)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .hsync_in          (hsync_in),
    .vsync_in          (vsync_in),
    .vde_in            (vde_in),
    .x_in              (x_in),
    .y_in              (y_in),
    .start_of_frame_in (start_of_frame_in),
    .end_of_line_in    (end_of_line_in),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .s_tuser           (s_tuser),
    .s_tlast           (s_tlast),
    .rgb_out           (rgb_out),
    .hsync_out         (hsync_out),
    .vsync_out         (vsync_out),
    .vde_out           (vde_out),
    .locked            (locked),
    .underflow_cnt     (underflow_cnt),
    .resync_cnt        (resync_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // raster position and scenario knobs
  int hc, vc, fid, short_y_next;
  bit auto_feed, stall_en, rand_sync;

  // stream source
  logic [23:0] sq_d[$];
  bit          sq_u[$];
  bit          sq_l[$];

  // scoreboard of {rgb, hsync, vsync, vde}
  logic [26:0] sb[$];

  // reference model of the lock protocol
  int m_st, m_under, m_resync;
  bit m_locked;

  bit          got_first;
  logic [23:0] first_pix;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [23:0] d, input bit u, input bit l);
    sq_d.push_back(d);
    sq_u.push_back(u);
    sq_l.push_back(l);
  endtask

  // Frame pixel = {frame id, y*HA+x}. A short line drops its last pixel and
  // moves tlast one column early.
  task automatic push_frame(input int id, input int short_y);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        if (!(y == short_y && x == HA - 1)) begin
          push_beat({8'(id), 16'(y * HA + x)}, (x == 0 && y == 0),
                    (x == HA - 1) || (y == short_y && x == HA - 2));
        end
      end
    end
  endtask

  task automatic sb_reset();
    sb.delete();
    for (int i = 0; i < PL - 1; i++) sb.push_back({24'h0, 3'b110});
  endtask

  task automatic model_reset();
    m_st = 0; m_locked = 0; m_under = 0; m_resync = 0;
  endtask

  task automatic cycle();
    bit          mr, mh, me, mu, stall;
    logic [23:0] mp;
    int          mn;
    logic [26:0] exp;

    x_in              = 10'(hc);
    y_in              = 10'(vc);
    vde_in            = (hc < HA) && (vc < VA);
    start_of_frame_in = (hc == 0) && (vc == 0);
    end_of_line_in    = (hc == HT - 1);
    if (rand_sync) begin
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
    end else begin
      hsync_in = !(hc >= HA + 1 && hc <= HA + 2);
      vsync_in = !(vc == VA + 1);
    end
    if (auto_feed && hc == 0 && vc == VA) begin
      push_frame(fid, short_y_next);
      fid++;
      short_y_next = -1;
    end
    stall    = stall_en && vc == 2 && hc >= 3 && hc < 8;
    s_tvalid = (sq_d.size() > 0) && !stall;
    s_tdata  = (sq_d.size() > 0) ? sq_d[0] : 24'h0;
    s_tuser  = (sq_d.size() > 0) ? sq_u[0] : 1'b0;
    s_tlast  = (sq_d.size() > 0) ? sq_l[0] : 1'b0;
    #1;

    case (m_st)
      0:       mr = s_tvalid && !s_tuser;
      1:       mr = start_of_frame_in && vde_in;
      default: mr = vde_in && !(s_tuser && !start_of_frame_in);
    endcase
    mh = s_tvalid && mr;
    me = (m_st == 2) && vde_in &&
         ((start_of_frame_in && (!s_tvalid || !s_tuser)) ||
          (s_tvalid && s_tuser && !start_of_frame_in) ||
          (mh && s_tlast && hc != HA - 1) ||
          (mh && !s_tlast && hc == HA - 1));
    mu = (m_st == 2) && vde_in && !s_tvalid && !me;
    if (mh && m_st != 0) mp = s_tdata;
    else if (vde_in)     mp = FILL;
    else                 mp = 24'h0;
    mn = m_st;
    if (m_st == 0 && s_tvalid && s_tuser) mn = 1;
    if (m_st == 1 && mh)                  mn = 2;
    if (m_st == 2 && me)                  mn = 0;

    chk("tready", s_tready, mr);
    sb.push_back({mp, hsync_in, vsync_in, vde_in});

    @(posedge clk);
    #1;
    if (mh) begin
      void'(sq_d.pop_front());
      void'(sq_u.pop_front());
      void'(sq_l.pop_front());
    end
    m_st     = mn;
    m_locked = (mn == 2);
    if (me && m_resync < 255)   m_resync++;
    if (mu && m_under < 65535)  m_under++;

    exp = sb.pop_front();
    chk("pipe", {rgb_out, hsync_out, vsync_out, vde_out}, exp);
    chk("status", {locked, underflow_cnt, resync_cnt}, {m_locked, 16'(m_under), 8'(m_resync)});
    if (!got_first && vde_out) begin
      got_first = 1;
      first_pix = rgb_out;
    end

    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rgb"}, rgb_out, 24'h0);
    chk({tag, "_sync"}, {hsync_out, vsync_out, vde_out}, 3'b110);
    chk({tag, "_stat"}, {locked, underflow_cnt, resync_cnt}, 25'h0);
    chk({tag, "_rdy"}, s_tready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; vde_in = 1'b0;
    x_in = '0; y_in = '0; start_of_frame_in = 1'b0; end_of_line_in = 1'b0;
    s_tdata = '0; s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0;
    auto_feed = 0; stall_en = 0; rand_sync = 0; short_y_next = -1;
    got_first = 0; first_pix = 'x;

    // reset values, with a valid non-SOF beat presented
    #7;
    chk_idle("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sb_reset();
    hc = 0; vc = VA; fid = 1;

    // leading garbage then clean frames; SOF at cycle 120 of this block
    for (int i = 0; i < 100; i++) push_beat(24'hEE0000 | 24'(i), 1'b0, 1'b0);
    auto_feed = 1;
    run(120);
    chk("prelock", locked, 1'b0);
    run(1);
    chk("lock_2nd_clk", locked, 1'b1);
    run(3 * FR - 121);
    chk("first_pixel", first_pix, {8'd1, 16'd0});
    chk("clean_cnts", {underflow_cnt, resync_cnt}, 24'h0);
    chk("clean_locked", locked, 1'b1);

    // five starved slots on line 2, then tlast arrives late
    stall_en = 1;
    run(FR);
    stall_en = 0;
    chk("uf_cnt", underflow_cnt, 16'd5);
    chk("uf_resync", resync_cnt, 8'd1);
    chk("uf_unlocked", locked, 1'b0);
    run(FR);
    chk("uf_relock", locked, 1'b1);

    // line 1 ends one pixel early
    short_y_next = 1;
    run(FR);
    chk("short_resync", resync_cnt, 8'd2);
    chk("short_unlocked", locked, 1'b0);
    chk("short_uf", underflow_cnt, 16'd5);
    run(FR);
    chk("short_relock", locked, 1'b1);

    // asynchronous reset in the middle of line 0
    run(130);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async_rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sb_reset();
    rand_sync = 1;
    run(FR - 130 + 2 * FR);
    rand_sync = 0;
    chk("rst_relock", locked, 1'b1);
    chk("rst_cnts", {underflow_cnt, resync_cnt}, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_stream_out.md
Name: video_stream_out

Overview:
Output stage directly downstream of video_timing. It consumes the timing generator's sync, enable and coordinate signals plus a valid/ready pixel stream from the vision pipeline, and emits pixel-aligned RGB with syncs delayed to match. It locks the stream to the raster using the SOF (tuser) and EOL (tlast) markers. It fills underflows with a constant colour and re-synchronises on framing errors.

Parameters:
DATA_W, 24, pixel width (RGB888)
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
PIPE_LAT, 2, output latency in clocks (>=1)
FILL_COLOR, 24'h000000, colour driven on underflow or when unlocked

Ports:
clk  in  1  pixel clock (~25 MHz)
reset  in  1  asynchronous, active-high
hsync_in  in  1  active-low hsync from timing generator
vsync_in  in  1  active-low vsync from timing generator
vde_in  in  1  active-video enable
x_in  in  10  horizontal counter
y_in  in  10  vertical counter
start_of_frame_in  in  1  high at x=0, y=0
end_of_line_in  in  1  high on last clock of line
s_tdata  in  DATA_W  stream pixel
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready (combinational)
s_tuser  in  1  first pixel of frame
s_tlast  in  1  last pixel of line
rgb_out  out  DATA_W  pixel to encoder
hsync_out  out  1  hsync_in delayed PIPE_LAT
vsync_out  out  1  vsync_in delayed PIPE_LAT
vde_out  out  1  vde_in delayed PIPE_LAT
locked  out  1  registered; high while in ACTIVE
underflow_cnt  out  16  saturating count of starved active pixels
resync_cnt  out  8  saturating count of framing errors

Behaviour:
- Reset values: rgb_out=0, hsync_out=1, vsync_out=1, vde_out=0, locked=0, both counters=0, state=WAIT_SOF, delay line filled with the same idle values. s_tready=0 while reset is high.
- FSM: WAIT_SOF, ARMED, ACTIVE.
- WAIT_SOF:
  - s_tready = s_tvalid && !s_tuser, so non-SOF pixels are flushed.
  - On s_tvalid && s_tuser, go to ARMED. The SOF pixel is not consumed.
- ARMED:
  - s_tready = start_of_frame_in && vde_in.
  - On that handshake, go to ACTIVE.
- ACTIVE:
  - s_tready = vde_in, with one exception: if s_tuser is high and start_of_frame_in is low, s_tready=0.
- Framing errors (checked on cycles where vde_in=1 in ACTIVE): resync_cnt++ and next state is WAIT_SOF on any of:
  - start_of_frame_in with (!s_tvalid or !s_tuser);
  - s_tuser valid when not start_of_frame_in;
  - handshake with s_tlast=1 and x_in != H_ACTIVE-1;
  - handshake with s_tlast=0 and x_in == H_ACTIVE-1.
- Error-cycle pixel: on an error that does not handshake, the output pixel is FILL_COLOR. On an error that does handshake, the stream pixel is output.
- Underflow: ACTIVE && vde_in && !s_tvalid (and no framing error) outputs FILL_COLOR and increments underflow_cnt (saturating at 16'hFFFF). The raster slot is lost; no catch-up. The misalignment surfaces at the next tlast check.
- Pixel select (cycle 0):
  - handshake -> s_tdata;
  - vde_in without handshake -> FILL_COLOR;
  - !vde_in -> 0.
- Pipeline: the selected pixel, hsync_in, vsync_in and vde_in pass through identical PIPE_LAT-deep registers. Output at cycle N reflects inputs at cycle N-PIPE_LAT, in every state.
- locked: equals (state==ACTIVE) registered, i.e. it rises one clock after the ARMED->ACTIVE handshake.
- Counter saturation: resync_cnt saturates at 8'hFF.
- Counter clearing: counters clear only on reset.
- Reset mid-frame: all state clears asynchronously and the first accepted pixel after release must carry tuser.

Decomposition:
- video_pkg holds:
  - H_ACTIVE, V_ACTIVE, DATA_W defaults;
  - rgb_t (logic [23:0]);
  - stream_state_e enum {WAIT_SOF, ARMED, ACTIVE}.
- Sub-module video_delay_line: parameterised width/depth shift register with an async-reset value per bit. It is instantiated once for {pixel, hsync, vsync, vde}.

Test Plan:
- Clean frame: 640x480 stream, pixel value = y*640+x, tuser at (0,0), tlast at x=639 -> locked=1 from second clock of frame, rgb_out equals pixel exactly 2 clocks after its vde_in slot, both counters 0.
- Leading garbage: 100 pixels without tuser before SOF pixel -> all 100 accepted and dropped, first vde_out pixel equals SOF pixel value, resync_cnt=0.
- Underflow: s_tvalid low for 5 active clocks on line 10 -> 5 FILL_COLOR pixels, underflow_cnt=5, late tlast -> resync_cnt=1, locked falls, relocks at next frame's SOF.
- Short line: tlast at x=638 -> resync_cnt=1, state WAIT_SOF, remaining active pixels of frame = FILL_COLOR.
- Sync alignment: random raster including blanking and unlocked periods -> hsync_out/vsync_out/vde_out equal inputs delayed exactly PIPE_LAT=2.
- Async reset asserted mid-line -> outputs reach reset values without a clock edge, s_tready=0; after release, pixels without tuser are flushed until a tuser pixel arrives.
